// File: rtl/id_stage_hazard.sv
// id_stage_hazard: decode stage of the 5-stage MIPS pipeline.
// Holds the register bank, the load-use / branch-operand hazard detector,
// early branch and jump resolution with IF flush, and the ID/EX register.
//
// Flow semantics: i_ID_valid marks a real instruction in IF/ID. The
// instruction is consumed at the clock edge when i_ID_enable=1 and
// o_ID_stall=0. While o_ID_stall=1 the upstream stages must hold PC and
// IF/ID, and a bubble (valid=0) is inserted into ID/EX instead.
module id_stage_hazard #(
    parameter int NB_INST = 32,
    parameter int NB_PC   = 32,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 16
) (
    input  logic               i_clock,
    input  logic               i_ID_reset,
    input  logic               i_ID_enable,
    input  logic               i_ID_valid,
    input  logic [NB_INST-1:0] i_ID_inst,
    input  logic [NB_PC-1:0]   i_ID_pc,
    input  logic [NB_CTRL-1:0] i_ID_ctrl,
    input  logic               i_ID_uses_rs,
    input  logic               i_ID_uses_rt,
    input  logic               i_ID_reg_write,
    input  logic               i_ID_reg_dest,
    input  logic               i_ID_mem_read,
    input  logic               i_ID_link,
    input  logic               i_ID_beq,
    input  logic               i_ID_bne,
    input  logic               i_ID_jump,
    input  logic               i_ID_jr,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_read,
    input  logic [NB_REG-1:0]  i_MEM_write_reg,
    input  logic [NB_DATA-1:0] i_MEM_alu_result,
    input  logic               i_WB_reg_write,
    input  logic [NB_REG-1:0]  i_WB_write_reg,
    input  logic [NB_DATA-1:0] i_WB_write_data,
    output logic               o_ID_stall,
    output logic               o_ID_pc_src,
    output logic               o_ID_flush_if,
    output logic [NB_PC-1:0]   o_ID_target,
    output logic               o_EX_valid,
    output logic               o_EX_reg_write,
    output logic               o_EX_mem_read,
    output logic               o_EX_link,
    output logic [NB_CTRL-1:0] o_EX_ctrl,
    output logic [NB_DATA-1:0] o_EX_data_a,
    output logic [NB_DATA-1:0] o_EX_data_b,
    output logic [NB_DATA-1:0] o_EX_immediate,
    output logic [NB_REG-1:0]  o_EX_rs,
    output logic [NB_REG-1:0]  o_EX_rt,
    output logic [NB_REG-1:0]  o_EX_dest,
    output logic [NB_PC-1:0]   o_EX_pc
);

    localparam int NREGS = 2 ** NB_REG;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               link;
        logic [NB_CTRL-1:0] ctrl;
        logic [NB_DATA-1:0] data_a;
        logic [NB_DATA-1:0] data_b;
        logic [NB_DATA-1:0] imm;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  dest;
        logic [NB_PC-1:0]   pc;
    } id_ex_t;

    logic [NB_DATA-1:0] bank_q [NREGS];
    logic [NB_DATA-1:0] bank_d [NREGS];
    id_ex_t             ex_q;
    id_ex_t             ex_d;

    logic [NB_REG-1:0]  rs_addr, rt_addr, rd_addr, dest_addr;
    logic [15:0]        imm16;
    logic [NB_DATA-1:0] rs_val, rt_val, rs_br, rt_br;
    logic               ex_hit, mem_hit, is_branch, hazard, go, taken;
    logic [NB_PC-1:0]   br_target, j_target, target;
    logic               unused_bits;

    // Opcode/funct bits above the jump field are decoded in control_unit.
    assign unused_bits = ^i_ID_inst[NB_INST-1:26];

    assign rs_addr = i_ID_inst[21 +: NB_REG];
    assign rt_addr = i_ID_inst[16 +: NB_REG];
    assign rd_addr = i_ID_inst[11 +: NB_REG];
    assign imm16   = i_ID_inst[15:0];

    // Destination select: link forces the top register (r31).
    always_comb begin
        dest_addr = rt_addr;
        if (i_ID_link) begin
            dest_addr = '1;
        end else if (i_ID_reg_dest) begin
            dest_addr = rd_addr;
        end
    end

    // Bank next state: WB write, gated by the global enable, never to r0.
    always_comb begin
        bank_d = bank_q;
        if (i_ID_enable && i_WB_reg_write && (i_WB_write_reg != '0)) begin
            bank_d[i_WB_write_reg] = i_WB_write_data;
        end
    end

    // Bank storage.
    always_ff @(posedge i_clock) begin
        if (!i_ID_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    // Write-first reads, then MEM bypass for the values the branch unit sees.
    // A load in MEM is not bypassed here; its result is not ready yet.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs_addr != '0) begin
            rs_val = (i_WB_reg_write && (i_WB_write_reg == rs_addr)) ? i_WB_write_data
                                                                     : bank_q[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_val = (i_WB_reg_write && (i_WB_write_reg == rt_addr)) ? i_WB_write_data
                                                                     : bank_q[rt_addr];
        end
        rs_br = rs_val;
        rt_br = rt_val;
        if (i_MEM_reg_write && !i_MEM_mem_read && (i_MEM_write_reg != '0)) begin
            if (i_MEM_write_reg == rs_addr) rs_br = i_MEM_alu_result;
            if (i_MEM_write_reg == rt_addr) rt_br = i_MEM_alu_result;
        end
    end

    // Hazard detection: match of a used, non-zero source against EX / MEM dest.
    always_comb begin
        ex_hit    = (i_ID_uses_rs && (rs_addr != '0) && (rs_addr == ex_q.dest)) ||
                    (i_ID_uses_rt && (rt_addr != '0) && (rt_addr == ex_q.dest));
        mem_hit   = (i_ID_uses_rs && (rs_addr != '0) && (rs_addr == i_MEM_write_reg)) ||
                    (i_ID_uses_rt && (rt_addr != '0) && (rt_addr == i_MEM_write_reg));
        is_branch = i_ID_beq || i_ID_bne || i_ID_jr;
        hazard    = i_ID_valid &&
                    ((ex_q.valid && ex_q.mem_read && ex_hit) ||
                     (is_branch && ex_q.reg_write && ex_hit) ||
                     (is_branch && i_MEM_mem_read && mem_hit));
    end

    // Early branch / jump resolution; a stall always wins over a redirect.
    always_comb begin
        go        = i_ID_reset && i_ID_enable && i_ID_valid && !hazard;
        br_target = i_ID_pc + {{(NB_PC-16){imm16[15]}}, imm16};
        j_target  = {i_ID_pc[NB_PC-1:26], i_ID_inst[25:0]};
        target    = br_target;
        if (i_ID_jr) begin
            target = rs_br[NB_PC-1:0];
        end else if (i_ID_jump) begin
            target = j_target;
        end
        taken = go && ((i_ID_beq && (rs_br == rt_br)) ||
                       (i_ID_bne && (rs_br != rt_br)) ||
                       i_ID_jump || i_ID_jr);
        o_ID_stall    = i_ID_reset && i_ID_enable && hazard;
        o_ID_pc_src   = taken;
        o_ID_flush_if = taken;
        o_ID_target   = taken ? target : '0;
    end

    // ID/EX next state: a fully zeroed bubble unless a real instruction issues.
    always_comb begin
        ex_d = '0;
        if (i_ID_valid && !hazard) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = i_ID_reg_write;
            ex_d.mem_read  = i_ID_mem_read;
            ex_d.link      = i_ID_link;
            ex_d.ctrl      = i_ID_ctrl;
            ex_d.data_a    = rs_val;
            ex_d.data_b    = rt_val;
            ex_d.imm       = {{(NB_DATA-16){imm16[15]}}, imm16};
            ex_d.rs        = rs_addr;
            ex_d.rt        = rt_addr;
            ex_d.dest      = dest_addr;
            ex_d.pc        = i_ID_pc;
        end
    end

    // ID/EX register: advances only with the global enable.
    always_ff @(posedge i_clock) begin
        if (!i_ID_reset) begin
            ex_q <= '0;
        end else if (i_ID_enable) begin
            ex_q <= ex_d;
        end
    end

    assign o_EX_valid     = ex_q.valid;
    assign o_EX_reg_write = ex_q.reg_write;
    assign o_EX_mem_read  = ex_q.mem_read;
    assign o_EX_link      = ex_q.link;
    assign o_EX_ctrl      = ex_q.ctrl;
    assign o_EX_data_a    = ex_q.data_a;
    assign o_EX_data_b    = ex_q.data_b;
    assign o_EX_immediate = ex_q.imm;
    assign o_EX_rs        = ex_q.rs;
    assign o_EX_rt        = ex_q.rt;
    assign o_EX_dest      = ex_q.dest;
    assign o_EX_pc        = ex_q.pc;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard: bank bypass, hazards, redirects,
// enable hold and reset, with hand-computed expectations.
module tb_id_stage_hazard;

    logic        i_clock;
    logic        i_ID_reset, i_ID_enable, i_ID_valid;
    logic [31:0] i_ID_inst, i_ID_pc;
    logic [15:0] i_ID_ctrl;
    logic        i_ID_uses_rs, i_ID_uses_rt, i_ID_reg_write, i_ID_reg_dest;
    logic        i_ID_mem_read, i_ID_link, i_ID_beq, i_ID_bne, i_ID_jump, i_ID_jr;
    logic        i_MEM_reg_write, i_MEM_mem_read;
    logic [4:0]  i_MEM_write_reg;
    logic [31:0] i_MEM_alu_result;
    logic        i_WB_reg_write;
    logic [4:0]  i_WB_write_reg;
    logic [31:0] i_WB_write_data;
    logic        o_ID_stall, o_ID_pc_src, o_ID_flush_if;
    logic [31:0] o_ID_target;
    logic        o_EX_valid, o_EX_reg_write, o_EX_mem_read, o_EX_link;
    logic [15:0] o_EX_ctrl;
    logic [31:0] o_EX_data_a, o_EX_data_b, o_EX_immediate, o_EX_pc;
    logic [4:0]  o_EX_rs, o_EX_rt, o_EX_dest;

    id_stage_hazard dut (
        .i_clock(i_clock), .i_ID_reset(i_ID_reset), .i_ID_enable(i_ID_enable),
        .i_ID_valid(i_ID_valid), .i_ID_inst(i_ID_inst), .i_ID_pc(i_ID_pc),
        .i_ID_ctrl(i_ID_ctrl), .i_ID_uses_rs(i_ID_uses_rs), .i_ID_uses_rt(i_ID_uses_rt),
        .i_ID_reg_write(i_ID_reg_write), .i_ID_reg_dest(i_ID_reg_dest),
        .i_ID_mem_read(i_ID_mem_read), .i_ID_link(i_ID_link), .i_ID_beq(i_ID_beq),
        .i_ID_bne(i_ID_bne), .i_ID_jump(i_ID_jump), .i_ID_jr(i_ID_jr),
        .i_MEM_reg_write(i_MEM_reg_write), .i_MEM_mem_read(i_MEM_mem_read),
        .i_MEM_write_reg(i_MEM_write_reg), .i_MEM_alu_result(i_MEM_alu_result),
        .i_WB_reg_write(i_WB_reg_write), .i_WB_write_reg(i_WB_write_reg),
        .i_WB_write_data(i_WB_write_data), .o_ID_stall(o_ID_stall),
        .o_ID_pc_src(o_ID_pc_src), .o_ID_flush_if(o_ID_flush_if),
        .o_ID_target(o_ID_target), .o_EX_valid(o_EX_valid),
        .o_EX_reg_write(o_EX_reg_write), .o_EX_mem_read(o_EX_mem_read),
        .o_EX_link(o_EX_link), .o_EX_ctrl(o_EX_ctrl), .o_EX_data_a(o_EX_data_a),
        .o_EX_data_b(o_EX_data_b), .o_EX_immediate(o_EX_immediate),
        .o_EX_rs(o_EX_rs), .o_EX_rt(o_EX_rt), .o_EX_dest(o_EX_dest), .o_EX_pc(o_EX_pc)
    );

    // Clock
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard for o_EX_data_a: expectation pushed when the instruction is driven.
    task automatic check_q(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(tag, got, e);
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h04, rs, rt, imm};
    endfunction

    task automatic clear_id();
        i_ID_valid = 0; i_ID_inst = 0; i_ID_pc = 0; i_ID_ctrl = 0;
        i_ID_uses_rs = 0; i_ID_uses_rt = 0; i_ID_reg_write = 0; i_ID_reg_dest = 0;
        i_ID_mem_read = 0; i_ID_link = 0; i_ID_beq = 0; i_ID_bne = 0;
        i_ID_jump = 0; i_ID_jr = 0;
    endtask

    task automatic mem_drive(input logic rw, input logic mr, input logic [4:0] a, input logic [31:0] d);
        i_MEM_reg_write = rw; i_MEM_mem_read = mr; i_MEM_write_reg = a; i_MEM_alu_result = d;
    endtask

    task automatic wb_drive(input logic we, input logic [4:0] a, input logic [31:0] d);
        i_WB_reg_write = we; i_WB_write_reg = a; i_WB_write_data = d;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        clear_id();
        wb_drive(1, a, d);
        step();
        wb_drive(0, 0, 0);
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] pc);
        clear_id();
        i_ID_valid = 1; i_ID_inst = enc_r(rs, rt, rd); i_ID_pc = pc; i_ID_ctrl = 16'hBEEF;
        i_ID_uses_rs = 1; i_ID_uses_rt = 1; i_ID_reg_write = 1; i_ID_reg_dest = 1;
    endtask

    task automatic drive_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] pc);
        clear_id();
        i_ID_valid = 1; i_ID_inst = enc_i(rs, rt, 16'd0); i_ID_pc = pc; i_ID_ctrl = 16'h0011;
        i_ID_uses_rs = 1; i_ID_reg_write = 1; i_ID_mem_read = 1;
    endtask

    task automatic drive_br(input logic is_bne, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [15:0] imm, input logic [31:0] pc);
        clear_id();
        i_ID_valid = 1; i_ID_inst = enc_i(rs, rt, imm); i_ID_pc = pc;
        i_ID_uses_rs = 1; i_ID_uses_rt = 1; i_ID_beq = !is_bne; i_ID_bne = is_bne;
    endtask

    task automatic drive_jal(input logic [25:0] t, input logic [31:0] pc);
        clear_id();
        i_ID_valid = 1; i_ID_inst = {6'h03, t}; i_ID_pc = pc; i_ID_ctrl = 16'h0300;
        i_ID_jump = 1; i_ID_link = 1; i_ID_reg_write = 1;
    endtask

    task automatic drive_jr(input logic [4:0] rs, input logic [31:0] pc);
        clear_id();
        i_ID_valid = 1; i_ID_inst = enc_r(rs, 5'd0, 5'd0); i_ID_pc = pc;
        i_ID_uses_rs = 1; i_ID_jr = 1;
    endtask

    initial begin
        i_ID_reset = 0; i_ID_enable = 1;
        clear_id(); mem_drive(0, 0, 0, 0); wb_drive(0, 0, 0);

        // Reset: redirects forced off, EX register cleared
        drive_jal(26'h100, 32'h1);
        #1;
        check("rst_pc_src", o_ID_pc_src, 0);
        check("rst_flush", o_ID_flush_if, 0);
        step(); step();
        check("rst_ex_valid", o_EX_valid, 0);
        check("rst_ex_pc", o_EX_pc, 0);
        check("rst_ex_dest", o_EX_dest, 0);
        i_ID_reset = 1;

        // Preload the bank
        wb_write(1, 32'd7); wb_write(2, 32'd7); wb_write(3, 32'h33);
        wb_write(9, 32'd9); wb_write(31, 32'h1234);

        // Write-first read of r5
        drive_alu(6, 5, 0, 32'h8); wb_drive(1, 5, 32'hAA); exp_q.push_back(32'hAA);
        step(); wb_drive(0, 0, 0);
        check_q("wf_data_a", o_EX_data_a);
        check("wf_valid", o_EX_valid, 1);
        check("wf_dest", o_EX_dest, 6);
        check("wf_ctrl", o_EX_ctrl, 32'hBEEF);

        // Writes to r0 are dropped, including the bypass path
        drive_alu(6, 0, 1, 32'h9); wb_drive(1, 0, 32'h55); exp_q.push_back(0);
        step(); wb_drive(0, 0, 0);
        check_q("r0_bypass", o_EX_data_a);
        check("r0_data_b", o_EX_data_b, 7);
        drive_alu(6, 0, 1, 32'hA); exp_q.push_back(0);
        step();
        check_q("r0_read", o_EX_data_a);

        // Load-use: one stall, one bubble, then the add issues
        drive_lw(3, 1, 32'hC);
        step();
        drive_alu(4, 3, 1, 32'hD);
        #1;
        check("lu_stall", o_ID_stall, 1);
        step();
        check("lu_bub_valid", o_EX_valid, 0);
        check("lu_bub_rw", o_EX_reg_write, 0);
        check("lu_bub_ctrl", o_EX_ctrl, 0);
        check("lu_stall_clr", o_ID_stall, 0);
        step();
        check("lu_iss_valid", o_EX_valid, 1);
        check("lu_iss_dest", o_EX_dest, 4);
        check("lu_iss_a", o_EX_data_a, 32'h33);

        // beq r1,r2,+4 at PC+1=0x10
        drive_br(0, 1, 2, 16'd4, 32'h10);
        #1;
        check("beq_pc_src", o_ID_pc_src, 1);
        check("beq_flush", o_ID_flush_if, 1);
        check("beq_target", o_ID_target, 32'h14);
        check("beq_stall", o_ID_stall, 0);
        wb_drive(1, 2, 32'd8);
        #1;
        check("beq_nt_pc_src", o_ID_pc_src, 0);
        check("beq_nt_target", o_ID_target, 0);
        step(); wb_drive(0, 0, 0);

        // bne r7,r9 with r7 forwarded from MEM (9 == 9 -> not taken)
        mem_drive(1, 0, 7, 32'd9);
        drive_br(1, 7, 9, 16'hFFFC, 32'h20);
        #1;
        check("bne_fwd_pc_src", o_ID_pc_src, 0);
        check("bne_fwd_stall", o_ID_stall, 0);
        mem_drive(0, 0, 0, 0);

        // Producer in EX: one stall, then resolve with it in MEM (5 != 9 -> taken)
        drive_alu(7, 1, 0, 32'h1F);
        step();
        drive_br(1, 7, 9, 16'hFFFC, 32'h20);
        #1;
        check("bne_ex_stall", o_ID_stall, 1);
        check("bne_ex_pc_src", o_ID_pc_src, 0);
        check("bne_ex_target", o_ID_target, 0);
        step();
        mem_drive(1, 0, 7, 32'd5);
        #1;
        check("bne_res_stall", o_ID_stall, 0);
        check("bne_res_pc_src", o_ID_pc_src, 1);
        check("bne_res_target", o_ID_target, 32'h1C);
        mem_drive(0, 1, 7, 0);
        #1;
        check("bne_memld_stall", o_ID_stall, 1);
        mem_drive(0, 0, 0, 0);
        step();

        // jal then jr r31
        drive_jal(26'h100, 32'hF000_0001);
        #1;
        check("jal_target", o_ID_target, 32'hF000_0100);
        check("jal_pc_src", o_ID_pc_src, 1);
        step();
        check("jal_dest", o_EX_dest, 31);
        check("jal_link", o_EX_link, 1);
        check("jal_pc", o_EX_pc, 32'hF000_0001);
        drive_jr(31, 32'h50);
        #1;
        check("jr_stall", o_ID_stall, 1);
        check("jr_stall_target", o_ID_target, 0);
        step();
        check("jr_target", o_ID_target, 32'h1234);
        check("jr_pc_src", o_ID_pc_src, 1);
        step();
        check("jr_ex_pc", o_EX_pc, 32'h50);

        // Enable low for 3 cycles: EX holds, no redirect, no bank write
        i_ID_enable = 0;
        drive_br(0, 1, 1, 16'd8, 32'h60);
        wb_drive(1, 11, 32'h77);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("en_pc_src", o_ID_pc_src, 0);
            check("en_flush", o_ID_flush_if, 0);
            step();
            check("en_hold_pc", o_EX_pc, 32'h50);
            check("en_hold_valid", o_EX_valid, 1);
        end
        i_ID_enable = 1;
        wb_drive(0, 0, 0);
        drive_alu(12, 11, 1, 32'h70); exp_q.push_back(0);
        step();
        check_q("en_no_write", o_EX_data_a);
        check("en_resume_pc", o_EX_pc, 32'h70);

        // One-cycle reset mid-stream
        i_ID_reset = 0;
        drive_jal(26'h200, 32'h90);
        #1;
        check("rst2_pc_src", o_ID_pc_src, 0);
        step();
        check("rst2_ex_valid", o_EX_valid, 0);
        check("rst2_ex_pc", o_EX_pc, 0);
        i_ID_reset = 1;
        drive_alu(13, 1, 0, 32'h80); exp_q.push_back(0);
        step();
        check_q("rst2_r1", o_EX_data_a);
        check("rst2_pc", o_EX_pc, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline. It contains the register bank, the load-use and branch-operand hazard detector, early branch and jump resolution in ID with IF flush, and the ID/EX pipeline register. Control decode stays in control_unit; its signals arrive here as inputs. Sits between the IF/ID register and the EX stage.

Parameters:
NB_INST, 32, instruction width
NB_PC, 32, PC width (word-addressed; i_ID_pc carries PC+1)
NB_DATA, 32, register data width
NB_REG, 5, register address width; bank has 2**NB_REG entries
NB_CTRL, 16, width of the opaque control bundle passed through to EX/MEM/WB

Ports:
i_clock  in  1  clock
i_ID_reset  in  1  synchronous, active-low reset
i_ID_enable  in  1  global advance enable from the debug unit
i_ID_valid  in  1  IF/ID holds a real instruction
i_ID_inst  in  NB_INST  instruction
i_ID_pc  in  NB_PC  PC+1 of the instruction
i_ID_ctrl  in  NB_CTRL  pass-through control bundle
i_ID_uses_rs, i_ID_uses_rt  in  1 each  instruction reads rs / rt
i_ID_reg_write, i_ID_reg_dest, i_ID_mem_read, i_ID_link  in  1 each  writes a register / destination is rd (else rt) / load / jal or jalr (destination is r31)
i_ID_beq, i_ID_bne, i_ID_jump, i_ID_jr  in  1 each  branch and jump class
i_MEM_reg_write, i_MEM_mem_read  in  1 each  MEM-stage instruction writes a register / is a load
i_MEM_write_reg  in  NB_REG  MEM-stage destination
i_MEM_alu_result  in  NB_DATA  MEM-stage ALU result, used for forwarding
i_WB_reg_write  in  1  WB write enable
i_WB_write_reg  in  NB_REG  WB address
i_WB_write_data  in  NB_DATA  WB data
o_ID_stall  out  1  hold PC and IF/ID
o_ID_pc_src  out  1  redirect PC to o_ID_target
o_ID_flush_if  out  1  squash IF/ID
o_ID_target  out  NB_PC  redirect address
o_EX_valid, o_EX_reg_write, o_EX_mem_read, o_EX_link  out  1 each  registered
o_EX_ctrl  out  NB_CTRL  registered
o_EX_data_a, o_EX_data_b  out  NB_DATA  registered rs / rt values
o_EX_immediate  out  NB_DATA  registered sign-extended inst[15:0]
o_EX_rs, o_EX_rt, o_EX_dest  out  NB_REG  registered
o_EX_pc  out  NB_PC  registered PC+1

Behaviour:
- Reset (i_ID_reset=0 at a clock edge): all bank entries and all registered outputs are cleared to 0. Combinational outputs are forced to 0 while reset is low. Reset in the middle of a stall or branch abandons that operation.
- Register bank: r0 always reads 0. Writes occur at the clock edge when i_WB_reg_write=1, the address is non-zero and i_ID_enable=1. Reads are combinational and write-first: if the WB address matches a read address (non-zero) and WB is writing, the read returns i_WB_write_data.
- Destination: 2**NB_REG-1 if link, else rd if reg_dest, else rt.
- Branch operands: rs and rt values with a MEM bypass. If i_MEM_reg_write=1, i_MEM_mem_read=0 and the MEM address is non-zero and matches, the value is i_MEM_alu_result. Otherwise it is the bank read.
- Stall (combinational) asserts when i_ID_valid=1 and any of these hold:
  - (a) Load-use: o_EX_valid and o_EX_mem_read are 1, o_EX_dest is non-zero, and it matches a used source.
  - (b) Branch or jr instruction, o_EX_reg_write=1, and o_EX_dest is non-zero and matches a used source.
  - (c) Branch or jr instruction, i_MEM_mem_read=1, and i_MEM_write_reg is non-zero and matches a used source.
- Redirect (only when valid, not stalled and enabled):
  - beq taken if the operands are equal; bne taken if they are not equal.
  - Branch target = i_ID_pc + sign-extended imm16, modulo 2**NB_PC.
  - jump target = {i_ID_pc[NB_PC-1:26], inst[25:0]}.
  - jr target = the forwarded rs value.
  - o_ID_pc_src = o_ID_flush_if = taken. o_ID_target is 0 when not taken.
- ID/EX register, updated at the clock edge when i_ID_enable=1 (otherwise all registers hold):
  - If stalled or i_ID_valid=0: load a bubble. valid, reg_write, mem_read, link and ctrl become 0; the other fields are don't-care but zeroed.
  - Otherwise: capture all fields.
  - Latency: exactly 1 cycle.
- i_ID_enable=0: o_ID_stall, o_ID_pc_src and o_ID_flush_if are 0. There are no bank writes and no state change.
- Simultaneous stall and branch condition: the stall wins; the branch is re-evaluated the next cycle.
- Reads of r0 never cause a hazard.

Test Plan:
- WB writes r5=0x0000_00AA while ID reads rs=5 in the same cycle -> o_EX_data_a=0x0000_00AA next cycle. A write to r0 -> r0 still reads 0.
- lw r3 in EX, ID add r4,r3,r1 -> o_ID_stall=1 for 1 cycle and a bubble in EX (o_EX_valid=0, o_EX_reg_write=0). The add issues the following cycle.
- beq r1,r2,+4 with r1=r2=7, i_ID_pc=0x10 -> o_ID_pc_src=1, o_ID_flush_if=1, o_ID_target=0x14. With r2=8 -> no redirect.
- bne whose rs is produced by an ALU op in MEM (i_MEM_alu_result=9, rt=9) -> the forwarded compare gives not taken. With the producer in EX -> 1 stall cycle, then resolution.
- jal with i_ID_pc=0xF000_0001, inst[25:0]=0x100 -> o_ID_target=0xF000_0100, and next cycle o_EX_dest=31, o_EX_link=1, o_EX_pc=0xF000_0001. jr r31 -> o_ID_target equals the r31 value.
- i_ID_enable=0 for 3 cycles mid-stream -> the EX outputs hold and no bank write occurs. Reset low for 1 cycle -> all outputs 0 and r1 reads 0.
